button_conditioner: RTL and testbench

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/btn_pkg.sv | 22 ++
 rtl/btn_debounce.sv | 96 +++++++++
 rtl/button_conditioner.sv | 99 +++++++++
 tb/tb_button_conditioner.sv | 125 ++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared types and default timing constants for the button conditioner.
// Optional auto-repeat on the increment key is enabled by defining BTN_AUTOREPEAT_EN.
package btn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_DB_PRESS   = 2'd1,
        ST_PRESSED    = 2'd2,
        ST_DB_RELEASE = 2'd3
    } btn_state_e;

    localparam int DEF_DEBOUNCE_CYCLES = 16;
    localparam int DEF_REPEAT_DELAY    = 1000;
    localparam int DEF_REPEAT_RATE     = 250;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Per-key conditioner: 2-flop synchronizer, debounce FSM with saturating counter,
// and a single-cycle pulse on each accepted press.
module btn_debounce
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CNT_W           = $clog2(DEF_DEBOUNCE_CYCLES) + 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       raw_n,
    output logic       pulse,
    output logic [1:0] state
);

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    btn_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pulse_q, pulse_d;
    logic             pressed;

    assign pressed = ~sync2_q;

    always_comb begin
        sync1_d = raw_n;
        sync2_d = sync1_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (pressed) begin
                    state_d = ST_DB_PRESS;
                    cnt_d   = '0;
                end
            end
            ST_DB_PRESS: begin
                if (!pressed) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d = ST_PRESSED;
                    cnt_d   = '0;
                    pulse_d = 1'b1;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_PRESSED: begin
                if (!pressed) begin
                    state_d = ST_DB_RELEASE;
                    cnt_d   = '0;
                end
            end
            ST_DB_RELEASE: begin
                // A pressed sample here is treated as release bounce: no new pulse.
                if (pressed) begin
                    state_d = ST_PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse = pulse_q;
    assign state = state_q;

endmodule

// File: rtl/button_conditioner.sv
// Two-key front end: debounced advance/increment pulses with advance-wins priority.
// Define BTN_AUTOREPEAT_EN to add hold-to-repeat on the increment key.
module button_conditioner
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE     = DEF_REPEAT_RATE
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       raw_btn0,
    input  logic       raw_btn1,
    output logic       advanceState,
    output logic       incrementBtn,
    output logic [1:0] debugState0,
    output logic [1:0] debugState1
);

    localparam int CNT_W = $clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE)) + 1;

    logic pulse0, pulse1;
    logic rep_pulse;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_key0 (
        .clock (clock),
        .reset (reset),
        .raw_n (raw_btn0),
        .pulse (pulse0),
        .state (debugState0)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_key1 (
        .clock (clock),
        .reset (reset),
        .raw_n (raw_btn1),
        .pulse (pulse1),
        .state (debugState1)
    );

`ifdef BTN_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);

    logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             rep_phase_q, rep_phase_d;
    logic             rep_pulse_q, rep_pulse_d;
    logic             inhibit;
    logic [CNT_W-1:0] rep_limit;

    // Repeat pauses (counter held) while the advance key is down or settling.
    assign inhibit   = (debugState0 == ST_PRESSED) || (debugState0 == ST_DB_RELEASE);
    assign rep_limit = rep_phase_q ? RATE_LAST : DELAY_LAST;

    always_comb begin
        rep_cnt_d   = rep_cnt_q;
        rep_phase_d = rep_phase_q;
        rep_pulse_d = 1'b0;
        if (debugState1 != ST_PRESSED) begin
            rep_cnt_d   = '0;
            rep_phase_d = 1'b0;
        end else if (!inhibit) begin
            if (rep_cnt_q >= rep_limit) begin
                rep_cnt_d   = '0;
                rep_phase_d = 1'b1;
                rep_pulse_d = 1'b1;
            end else if (rep_cnt_q != '1) begin
                rep_cnt_d = rep_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rep_cnt_q   <= '0;
            rep_phase_q <= 1'b0;
            rep_pulse_q <= 1'b0;
        end else begin
            rep_cnt_q   <= rep_cnt_d;
            rep_phase_q <= rep_phase_d;
            rep_pulse_q <= rep_pulse_d;
        end
    end

    assign rep_pulse = rep_pulse_q;
`else
    assign rep_pulse = 1'b0;
`endif

    assign advanceState = pulse0;
    assign incrementBtn = (pulse1 | rep_pulse) & ~pulse0;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3.
module tb_button_conditioner;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       raw_btn0 = 1'b1;
    logic       raw_btn1 = 1'b1;
    logic       advanceState;
    logic       incrementBtn;
    logic [1:0] debugState0;
    logic [1:0] debugState1;

    int checks = 0;
    int fails  = 0;

    always #5 clock = ~clock;

    button_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (10),
        .REPEAT_RATE     (3)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .raw_btn0     (raw_btn0),
        .raw_btn1     (raw_btn1),
        .advanceState (advanceState),
        .incrementBtn (incrementBtn),
        .debugState0  (debugState0),
        .debugState1  (debugState1)
    );

    task automatic check(input string tag, input int cyc, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s cycle %0d: observed %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic do_reset();
        raw_btn0 = 1'b1;
        raw_btn1 = 1'b1;
        reset    = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("rst_adv", -1, {1'b0, advanceState}, 2'd0);
        check("rst_inc", -1, {1'b0, incrementBtn}, 2'd0);
        check("rst_st0", -1, debugState0, 2'd0);
        check("rst_st1", -1, debugState1, 2'd0);
        reset = 1'b0;
    endtask

    function automatic logic rep_expected(input int k);
`ifdef BTN_AUTOREPEAT_EN
        return (k == 6) || (k == 16) || (k == 19) || (k == 22) || (k == 25) || (k == 28);
`else
        return (k == 6);
`endif
    endfunction

    initial begin
        // Clean press on key 0
        do_reset();
        for (int k = 0; k <= 14; k++) begin
            raw_btn0 = 1'b0;
            @(posedge clock); #1;
            check("clean_adv", k, {1'b0, advanceState}, {1'b0, k == 6});
            check("clean_inc", k, {1'b0, incrementBtn}, 2'd0);
            if (k >= 6) check("clean_st0", k, debugState0, 2'd2);
        end

        // Bounce on key 1: low 2, high 1, low 2, then high
        do_reset();
        for (int k = 0; k <= 14; k++) begin
            raw_btn1 = (k == 0 || k == 1 || k == 3 || k == 4) ? 1'b0 : 1'b1;
            @(posedge clock); #1;
            check("bounce_inc", k, {1'b0, incrementBtn}, 2'd0);
        end
        check("bounce_st1", 15, debugState1, 2'd0);

        // Hold key 1 for 30 cycles
        do_reset();
        for (int k = 0; k <= 30; k++) begin
            raw_btn1 = (k < 30) ? 1'b0 : 1'b1;
            @(posedge clock); #1;
            check("hold_inc", k, {1'b0, incrementBtn}, {1'b0, rep_expected(k)});
            check("hold_adv", k, {1'b0, advanceState}, 2'd0);
        end
        raw_btn1 = 1'b1;
        repeat (12) @(posedge clock);
        #1;
        check("hold_release_st1", 43, debugState1, 2'd0);

        // Both keys pressed together: advance wins
        do_reset();
        for (int k = 0; k <= 20; k++) begin
            raw_btn0 = 1'b0;
            raw_btn1 = 1'b0;
            @(posedge clock); #1;
            check("simul_adv", k, {1'b0, advanceState}, {1'b0, k == 6});
            check("simul_inc", k, {1'b0, incrementBtn}, 2'd0);
        end

        // Reset pulse mid-debounce while key 0 stays held
        do_reset();
        for (int k = 0; k <= 16; k++) begin
            raw_btn0 = 1'b0;
            reset    = (k == 3 || k == 4);
            @(posedge clock); #1;
            check("rsthold_adv", k, {1'b0, advanceState}, {1'b0, k == 11});
            if (k == 3 || k == 4) begin
                check("rsthold_st0", k, debugState0, 2'd0);
                check("rsthold_inc", k, {1'b0, incrementBtn}, 2'd0);
            end
            if (k >= 11) check("rsthold_pressed", k, debugState0, 2'd2);
        end
        reset    = 1'b0;
        raw_btn0 = 1'b1;

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
